uart_tx_frame_engine: RTL and testbench

//  Parametrised UART transmit engine: accepts a character via valid/ready, serialises it onto tx.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_tx_frame_engine_if.sv | 28 ++
 rtl/uart_tx_shift_reg.sv | 63 ++++++
 rtl/uart_tx_frame_engine.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_frame_engine.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit frame engine: FSM state encoding,
// tx output-mux select codes, default geometry and the tx mux helper.
package uart_pkg;

    localparam int DATA_WIDTH_DEF    = 8;
    localparam int MIN_DATA_BITS_DEF = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5,
        ST_BREAK  = 3'd6
    } tx_state_e;

    typedef enum logic [1:0] {
        SEL_START  = 2'd0,
        SEL_STOP   = 2'd1,
        SEL_DATA   = 2'd2,
        SEL_PARITY = 2'd3
    } tx_sel_e;

    function automatic logic tx_mux(input tx_sel_e sel, input logic data_bit, input logic parity_bit);
        logic v;
        case (sel)
            SEL_START:  v = 1'b0;
            SEL_DATA:   v = data_bit;
            SEL_PARITY: v = parity_bit;
            default:    v = 1'b1;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/uart_tx_frame_engine_if.sv
// Character handshake, frame configuration and serial/status outputs of the
// UART transmit engine, grouped with register-block (master) and engine (slave) views.
interface uart_tx_frame_engine_if #(parameter int DATA_WIDTH = 8);
    localparam int LEN_W = $clog2(DATA_WIDTH);

    logic                  baud_tick;
    logic                  data_valid;
    logic                  data_ready;
    logic [DATA_WIDTH-1:0] data_in;
    logic [LEN_W-1:0]      char_len;
    logic                  parity_en;
    logic                  parity_odd;
    logic                  two_stop;
    logic                  send_break;
    logic                  tx;
    logic                  busy;
    logic                  frame_done;

    modport master (
        output baud_tick, data_valid, data_in, char_len, parity_en, parity_odd, two_stop, send_break,
        input  data_ready, tx, busy, frame_done
    );

    modport slave (
        input  baud_tick, data_valid, data_in, char_len, parity_en, parity_odd, two_stop, send_break,
        output data_ready, tx, busy, frame_done
    );
endinterface

// File: rtl/uart_tx_shift_reg.sv
// Character shift register for the UART transmitter: loads a character, shifts
// right on data-bit ticks, counts bits sent and holds the parity of the active bits.
module uart_tx_shift_reg #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_W      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic                  i_shift,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [LEN_W-1:0]      i_len_m1,
    input  logic                  i_parity_odd,
    output logic                  o_next_bit,
    output logic                  o_parity,
    output logic                  o_last
);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [LEN_W-1:0]      r_bit_cnt;
    logic [LEN_W-1:0]      r_len_m1;
    logic                  r_parity;

    // Bits above the character length never reach the line, so they are excluded here.
    function automatic logic masked_parity(input logic [DATA_WIDTH-1:0] data,
                                           input logic [LEN_W-1:0] len_m1, input logic odd);
        logic acc;
        acc = odd;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i <= int'(len_m1)) begin
                acc = acc ^ data[i];
            end
        end
        return acc;
    endfunction

    // Load on accept, shift and count on each data-bit tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_len_m1  <= '0;
            r_parity  <= 1'b0;
        end else if (i_load) begin
            r_shift   <= i_data;
            r_bit_cnt <= '0;
            r_len_m1  <= i_len_m1;
            r_parity  <= masked_parity(i_data, i_len_m1, i_parity_odd);
        end else if (i_shift) begin
            r_shift   <= {1'b0, r_shift[DATA_WIDTH-1:1]};
            r_bit_cnt <= r_bit_cnt + LEN_W'(1);
        end else begin
            r_shift   <= r_shift;
            r_bit_cnt <= r_bit_cnt;
        end
    end

    // Bit that sits at the LSB after this cycle's update, so tx can be registered with no lag.
    assign o_next_bit = i_shift ? r_shift[1] : r_shift[0];
    assign o_parity   = r_parity;
    assign o_last     = (r_bit_cnt == r_len_m1);

endmodule

// File: rtl/uart_tx_frame_engine.sv
// UART transmit frame engine: start / data / optional parity / 1-2 stop bits paced by baud_tick.
// Optional break generation is built when UART_TX_BREAK_EN is defined.
module uart_tx_frame_engine
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int MIN_DATA_BITS = MIN_DATA_BITS_DEF
) (
    input  logic                   UCLK,
    input  logic                   reset,
    uart_tx_frame_engine_if.slave  bus
);

    localparam int               LEN_W      = $clog2(DATA_WIDTH);
    localparam logic [LEN_W-1:0] MIN_LEN_M1 = LEN_W'(MIN_DATA_BITS - 1);

    tx_state_e        r_state, w_state_n;
    logic             r_stop_cnt, w_stop_cnt_n;
    logic             r_parity_en, r_two_stop;
    logic             r_tx, r_busy, r_frame_done;
    logic             w_ready, w_accept, w_tick, w_done_n, w_tx_n;
    logic             w_next_bit, w_parity, w_last, w_shift;
    logic [LEN_W-1:0] w_len_m1;
    tx_sel_e          w_sel;

    assign w_tick   = bus.baud_tick;
    assign w_ready  = (r_state == ST_IDLE);
    assign w_accept = bus.data_valid & w_ready;
    assign w_len_m1 = (bus.char_len < MIN_LEN_M1) ? MIN_LEN_M1 : bus.char_len;
    assign w_shift  = (r_state == ST_DATA) & w_tick;

`ifndef UART_TX_BREAK_EN
    logic w_unused_break;
    assign w_unused_break = bus.send_break;
`endif

    uart_tx_shift_reg #(.DATA_WIDTH(DATA_WIDTH), .LEN_W(LEN_W)) u_shift (
        .clk          (UCLK),
        .reset        (reset),
        .i_load       (w_accept),
        .i_shift      (w_shift),
        .i_data       (bus.data_in),
        .i_len_m1     (w_len_m1),
        .i_parity_odd (bus.parity_odd),
        .o_next_bit   (w_next_bit),
        .o_parity     (w_parity),
        .o_last       (w_last)
    );

    // Next-state, stop counter and end-of-frame decode.
    always_comb begin
        w_state_n    = r_state;
        w_stop_cnt_n = r_stop_cnt;
        w_done_n     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_n = ST_ARMED;
`ifdef UART_TX_BREAK_EN
                end else if (bus.send_break) begin
                    w_state_n = ST_BREAK;
`endif
                end else begin
                    w_state_n = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (w_tick) w_state_n = ST_START;
                else        w_state_n = ST_ARMED;
            end
            ST_START: begin
                if (w_tick) w_state_n = ST_DATA;
                else        w_state_n = ST_START;
            end
            ST_DATA: begin
                if (w_tick && w_last) begin
                    w_state_n    = r_parity_en ? ST_PARITY : ST_STOP;
                    w_stop_cnt_n = 1'b0;
                end else begin
                    w_state_n = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_n    = ST_STOP;
                    w_stop_cnt_n = 1'b0;
                end else begin
                    w_state_n = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (w_tick && r_two_stop && !r_stop_cnt) begin
                    w_stop_cnt_n = 1'b1;
                end else if (w_tick) begin
                    w_state_n = ST_IDLE;
                    w_done_n  = 1'b1;
                end else begin
                    w_state_n = ST_STOP;
                end
            end
`ifdef UART_TX_BREAK_EN
            // Pre-setting the stop counter leaves exactly one stop bit after a break.
            ST_BREAK: begin
                if (w_tick && !bus.send_break) begin
                    w_state_n    = ST_STOP;
                    w_stop_cnt_n = 1'b1;
                end else begin
                    w_state_n = ST_BREAK;
                end
            end
`endif
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    // Line level follows the state being entered so tx changes on the same edge as the state.
    always_comb begin
        case (w_state_n)
            ST_START, ST_BREAK: w_sel = SEL_START;
            ST_DATA:            w_sel = SEL_DATA;
            ST_PARITY:          w_sel = SEL_PARITY;
            default:            w_sel = SEL_STOP;
        endcase
        w_tx_n = tx_mux(w_sel, w_next_bit, w_parity);
    end

    // State, latched frame configuration and registered outputs.
    always_ff @(posedge UCLK) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_stop_cnt   <= 1'b0;
            r_parity_en  <= 1'b0;
            r_two_stop   <= 1'b0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_stop_cnt   <= w_stop_cnt_n;
            r_tx         <= w_tx_n;
            r_busy       <= (w_state_n != ST_IDLE);
            r_frame_done <= w_done_n;
            if (w_accept) begin
                r_parity_en <= bus.parity_en;
                r_two_stop  <= bus.two_stop;
            end else begin
                r_parity_en <= r_parity_en;
                r_two_stop  <= r_two_stop;
            end
        end
    end

    assign bus.data_ready = w_ready;
    assign bus.tx         = r_tx;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Self-checking bench for uart_tx_frame_engine: scoreboard of expected line bit sequences,
// one task per scenario; the break scenario follows UART_TX_BREAK_EN.
module tb_uart_tx_frame_engine;

    typedef struct {
        logic [15:0] bits;
        int          n;
    } frame_t;

    logic UCLK  = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    frame_t sb_q[$];

    uart_tx_frame_engine_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_frame_engine #(.DATA_WIDTH(8), .MIN_DATA_BITS(5)) dut (
        .UCLK  (UCLK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 UCLK = ~UCLK;

    always @(posedge UCLK) cyc <= cyc + 1;

    initial begin
        bus.baud_tick = 1'b0;
        forever begin
            repeat (15) @(posedge UCLK);
            #1 bus.baud_tick = 1'b1;
            @(posedge UCLK);
            #1 bus.baud_tick = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference frame: start, clamped data bits LSB first, optional parity, stop bit(s).
    function automatic frame_t model_frame(logic [7:0] d, logic [2:0] clen, bit pe, bit po, bit ts);
        frame_t f;
        int     nb;
        logic   p;
        nb = (clen < 3'd4) ? 5 : int'(clen) + 1;
        f.bits = 16'h0000;
        f.n = 1;
        p = po;
        for (int i = 0; i < nb; i++) begin
            f.bits[f.n] = d[i];
            p = p ^ d[i];
            f.n++;
        end
        if (pe) begin f.bits[f.n] = p; f.n++; end
        f.bits[f.n] = 1'b1; f.n++;
        if (ts) begin f.bits[f.n] = 1'b1; f.n++; end
        return f;
    endfunction

    task automatic drive_char(input logic [7:0] d, input logic [2:0] clen, input bit pe, input bit po,
                              input bit ts, input bit push, output bit ok);
        int w;
        bus.data_in = d; bus.char_len = clen; bus.parity_en = pe;
        bus.parity_odd = po; bus.two_stop = ts; bus.data_valid = 1'b1;
        if (push) sb_q.push_back(model_frame(d, clen, pe, po, ts));
        w = 0;
        while (!bus.data_ready && w < 3000) begin @(posedge UCLK); #1; w++; end
        ok = bus.data_ready;
        if (ok) begin @(posedge UCLK); #1; end
        bus.data_valid = 1'b0;
    endtask

    task automatic capture(output frame_t f, output bit to);
        int w;
        bit tk;
        f.bits = 16'h0000; f.n = 0; to = 1'b0; w = 0;
        while (!bus.busy && w < 3000) begin @(posedge UCLK); #1; w++; end
        if (!bus.busy) begin to = 1'b1; return; end
        w = 0;
        while (w < 3000) begin
            @(posedge UCLK);
            tk = bus.baud_tick;
            #1;
            w++;
            if (bus.frame_done) return;
            if (tk && f.n < 16) begin f.bits[f.n] = bus.tx; f.n++; end
        end
        to = 1'b1;
    endtask

    task automatic wait_tick(output bit to);
        int w;
        bit tk;
        w = 0; tk = 1'b0;
        while (!tk && w < 100) begin @(posedge UCLK); tk = bus.baud_tick; #1; w++; end
        to = !tk;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge UCLK);
        #1;
        checks++; if (bus.tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b want 1", bus.tx); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", bus.frame_done); end
        checks++; if (bus.data_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", bus.data_ready); end
        reset = 1'b1;
        @(posedge UCLK); #1;
    endtask

    task automatic test_frame(input string nm, input logic [7:0] d, input logic [2:0] clen,
                              input bit pe, input bit po, input bit ts);
        frame_t got, exp;
        bit ok, to;
        drive_char(d, clen, pe, po, ts, 1'b1, ok);
        // configuration changes after accept must not touch the frame in flight
        bus.data_in = ~d; bus.char_len = 3'd0; bus.parity_en = ~pe; bus.two_stop = ~ts;
        checks++; if (!ok) begin failures++; $display("FAIL %s_accept: got ready=0 want 1", nm); end
        capture(got, to);
        checks++; if (to) begin failures++; $display("FAIL %s_timeout: got timeout want frame_done", nm); end
        exp = sb_q.pop_front();
        checks++; if (got.n !== exp.n) begin failures++; $display("FAIL %s_len: got %0d want %0d", nm, got.n, exp.n); end
        checks++; if (got.bits !== exp.bits) begin failures++; $display("FAIL %s_bits: got %h want %h", nm, got.bits, exp.bits); end
        @(posedge UCLK); #1;
        checks++; if (bus.frame_done !== 1'b0 || bus.busy !== 1'b0 || bus.tx !== 1'b1) begin
            failures++; $display("FAIL %s_after: got done=%b busy=%b tx=%b want 0 0 1", nm, bus.frame_done, bus.busy, bus.tx);
        end
    endtask

    task automatic test_reset_mid_frame();
        frame_t got, exp;
        bit ok, to, tk;
        int k, w;
        drive_char(8'h96, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, ok);
        k = 0; w = 0;
        while (k < 5 && w < 500) begin @(posedge UCLK); tk = bus.baud_tick; #1; w++; if (tk) k++; end
        repeat (3) @(posedge UCLK);
        #1 reset = 1'b0;
        @(posedge UCLK); #1;
        reset = 1'b1;
        checks++; if (bus.tx !== 1'b1) begin failures++; $display("FAIL midrst_tx: got %b want 1", bus.tx); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.data_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready: got %b want 1", bus.data_ready); end
        drive_char(8'h3C, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, ok);
        capture(got, to);
        exp = sb_q.pop_front();
        checks++; if (to || got.n !== exp.n) begin failures++; $display("FAIL midrst_len: got %0d want %0d", got.n, exp.n); end
        checks++; if (got.bits !== exp.bits) begin failures++; $display("FAIL midrst_bits: got %h want %h", got.bits, exp.bits); end
    endtask

    task automatic test_back_to_back();
        frame_t g1, g2, e1, e2;
        bit to1, to2;
        int done_cyc, acc_cyc, w;
        logic tx_armed;
        done_cyc = -1; acc_cyc = -100; tx_armed = 1'b0;
        fork
            begin
                bus.data_in = 8'h5A; bus.char_len = 3'd7; bus.parity_en = 1'b1;
                bus.parity_odd = 1'b0; bus.two_stop = 1'b0; bus.data_valid = 1'b1;
                sb_q.push_back(model_frame(8'h5A, 3'd7, 1'b1, 1'b0, 1'b0));
                w = 0;
                while (!bus.data_ready && w < 3000) begin @(posedge UCLK); #1; w++; end
                @(posedge UCLK); #1;
                bus.data_in = 8'hC3; bus.char_len = 3'd5; bus.parity_en = 1'b1; bus.parity_odd = 1'b1;
                sb_q.push_back(model_frame(8'hC3, 3'd5, 1'b1, 1'b1, 1'b0));
                w = 0;
                while (!bus.data_ready && w < 3000) begin @(posedge UCLK); #1; w++; end
                @(posedge UCLK); #1;
                acc_cyc = cyc; tx_armed = bus.tx;
                bus.data_valid = 1'b0;
            end
            begin
                capture(g1, to1);
                done_cyc = cyc;
                capture(g2, to2);
            end
        join
        e1 = sb_q.pop_front();
        e2 = sb_q.pop_front();
        checks++; if (to1 || g1.bits !== e1.bits || g1.n !== e1.n) begin failures++; $display("FAIL b2b_first: got %h/%0d want %h/%0d", g1.bits, g1.n, e1.bits, e1.n); end
        checks++; if (to2 || g2.bits !== e2.bits || g2.n !== e2.n) begin failures++; $display("FAIL b2b_second: got %h/%0d want %h/%0d", g2.bits, g2.n, e2.bits, e2.n); end
        checks++; if (acc_cyc !== done_cyc + 1) begin failures++; $display("FAIL b2b_accept_cycle: got %0d want %0d", acc_cyc, done_cyc + 1); end
        checks++; if (tx_armed !== 1'b1) begin failures++; $display("FAIL b2b_armed_tx: got %b want 1", tx_armed); end
    endtask

    task automatic test_random();
        frame_t got, exp;
        bit ok, to;
        logic [7:0] d;
        logic [2:0] cl;
        bit pe, po, ts;
        for (int r = 0; r < 6; r++) begin
            d = 8'($urandom_range(0, 255)); cl = 3'($urandom_range(0, 7));
            pe = 1'($urandom_range(0, 1)); po = 1'($urandom_range(0, 1)); ts = 1'($urandom_range(0, 1));
            drive_char(d, cl, pe, po, ts, 1'b1, ok);
            capture(got, to);
            exp = sb_q.pop_front();
            checks++; if (!ok || to || got.n !== exp.n || got.bits !== exp.bits) begin
                failures++; $display("FAIL rand%0d: got %h/%0d want %h/%0d", r, got.bits, got.n, exp.bits, exp.n);
            end
        end
    endtask

`ifdef UART_TX_BREAK_EN
    task automatic test_break();
        bit to;
        int bad;
        wait_tick(to);
        bus.send_break = 1'b1;
        @(posedge UCLK); #1;
        checks++; if (bus.tx !== 1'b0 || bus.busy !== 1'b1 || bus.data_ready !== 1'b0) begin
            failures++; $display("FAIL brk_enter: got tx=%b busy=%b rdy=%b want 0 1 0", bus.tx, bus.busy, bus.data_ready);
        end
        bad = 0;
        for (int t = 0; t < 20; t++) begin
            wait_tick(to);
            if (to || bus.tx !== 1'b0) bad++;
        end
        bus.send_break = 1'b0;
        checks++; if (bad !== 0) begin failures++; $display("FAIL brk_low: got %0d bad ticks want 0", bad); end
        wait_tick(to);
        checks++; if (bus.tx !== 1'b1 || bus.frame_done !== 1'b0) begin
            failures++; $display("FAIL brk_stop: got tx=%b done=%b want 1 0", bus.tx, bus.frame_done);
        end
        wait_tick(to);
        checks++; if (bus.frame_done !== 1'b1 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL brk_done: got done=%b busy=%b want 1 0", bus.frame_done, bus.busy);
        end
    endtask
`else
    task automatic test_break();
        int bad;
        bad = 0;
        bus.send_break = 1'b1;
        repeat (40) begin
            @(posedge UCLK); #1;
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.data_ready !== 1'b1) bad++;
        end
        bus.send_break = 1'b0;
        checks++; if (bad !== 0) begin failures++; $display("FAIL brk_ignored: got %0d disturbed cycles want 0", bad); end
    endtask
`endif

    initial begin
        bus.data_valid = 1'b0; bus.data_in = 8'h00; bus.char_len = 3'd7;
        bus.parity_en = 1'b0; bus.parity_odd = 1'b0; bus.two_stop = 1'b0; bus.send_break = 1'b0;
        test_reset();
        test_frame("8n1", 8'hA5, 3'd7, 1'b0, 1'b0, 1'b0);
        test_frame("7e2", 8'h41, 3'd6, 1'b1, 1'b0, 1'b1);
        test_frame("5o1", 8'hFF, 3'd0, 1'b1, 1'b1, 1'b0);
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        test_break();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
